// File: rtl/color_pkg.sv
// Shared constants and types for the colour ratio meter.
// Filter codes follow the sensor's S2/S3 select pins.
package color_pkg;

    localparam int PCT_W = 7;

    localparam logic [1:0] FLT_RED   = 2'b00;
    localparam logic [1:0] FLT_BLUE  = 2'b01;
    localparam logic [1:0] FLT_CLEAR = 2'b10;
    localparam logic [1:0] FLT_GREEN = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        DIV,
        DONE
    } state_t;

    // Measurement order: clear, green, red, blue.
    function automatic logic [1:0] phase_flt(input logic [1:0] ph);
        logic [1:0] f;
        unique case (ph)
            2'd0:    f = FLT_CLEAR;
            2'd1:    f = FLT_GREEN;
            2'd2:    f = FLT_RED;
            default: f = FLT_BLUE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pct_divider.sv
// Restoring divider producing floor(num*100/den), clamped to 100.
// One quotient bit per cycle; done pulses once the quotient is ready.
module pct_divider
    import color_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic             done,
    output logic [PCT_W-1:0] pct
);

    localparam int QW = CNT_W + 7;
    localparam int BW = $clog2(QW + 1);

    logic [QW-1:0]  q;
    logic [CNT_W:0] rem;
    logic [CNT_W:0] rem_sh;
    logic           ge;
    logic           run;
    logic [BW-1:0]  bits;

    // Dividend bits shift out of q's top while quotient bits shift in.
    assign rem_sh = {rem[CNT_W-1:0], q[QW-1]};
    assign ge     = (rem_sh >= {1'b0, den});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            rem  <= '0;
            run  <= 1'b0;
            bits <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q    <= QW'(num) * QW'(100);
                rem  <= '0;
                bits <= '0;
                run  <= 1'b1;
            end else if (run) begin
                rem  <= ge ? (rem_sh - {1'b0, den}) : rem_sh;
                q    <= {q[QW-2:0], ge};
                bits <= bits + BW'(1);
                if (bits == BW'(QW - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign pct = (q > QW'(100)) ? PCT_W'(100) : q[PCT_W-1:0];

endmodule

// File: rtl/color_ratio_meter.sv
// Colour sensor ratio meter: counts clear/green (and red/blue with
// COLOR_RATIO_RGB_EN) frequency windows and reports percent ratios.
module color_ratio_meter
    import color_pkg::*;
#(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 20,
    parameter int LO_PCT        = 57,
    parameter int HI_PCT        = 80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             freq_in,
    output logic [1:0]       filter,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [PCT_W-1:0] green_pct,
`ifdef COLOR_RATIO_RGB_EN
    output logic [PCT_W-1:0] red_pct,
    output logic [PCT_W-1:0] blue_pct,
`endif
    output logic             valid,
    output logic             color,
    output logic             div_err,
    output logic             busy
);

`ifdef COLOR_RATIO_RGB_EN
    localparam logic [1:0] LAST_PH  = 2'd3;
    localparam logic [1:0] LAST_DIV = 2'd2;
`else
    localparam logic [1:0] LAST_PH  = 2'd1;
    localparam logic [1:0] LAST_DIV = 2'd0;
`endif

    state_t           state, state_n;
    logic [2:0]       sync;
    logic             edge_p;
    logic [31:0]      timer;
    logic             settle_end;
    logic             gate_end;
    logic [1:0]       phase;
    logic [1:0]       div_idx;
    logic             div_start;
    logic             div_fin;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] clr_q, grn_q;
    logic [PCT_W-1:0] grn_p;
    logic [CNT_W-1:0] dv_num;
    logic             dv_done;
    logic [PCT_W-1:0] dv_pct;
`ifdef COLOR_RATIO_RGB_EN
    logic [CNT_W-1:0] red_q, blu_q;
    logic [PCT_W-1:0] red_p, blu_p;
`endif

    assign edge_p     = sync[1] & ~sync[2];
    assign settle_end = (timer == 32'(SETTLE_CYCLES - 1));
    assign gate_end   = (timer == 32'(GATE_CYCLES - 1));
    assign busy       = (state != IDLE);

    // Saturating edge count including the edge seen this cycle.
    assign cnt_nxt = (edge_p && cnt != {CNT_W{1'b1}})
                   ? cnt + CNT_W'(1) : cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en) state_n = SETTLE;
            SETTLE:  if (settle_end) state_n = GATE;
            GATE:    if (gate_end)
                         state_n = (phase == LAST_PH) ? DIV : SETTLE;
            DIV:     if (div_fin) state_n = DONE;
            DONE:    state_n = en ? SETTLE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        dv_num = grn_q;
`ifdef COLOR_RATIO_RGB_EN
        case (div_idx)
            2'd1:    dv_num = red_q;
            2'd2:    dv_num = blu_q;
            default: dv_num = grn_q;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync      <= '0;
            timer     <= '0;
            phase     <= '0;
            div_idx   <= '0;
            div_start <= 1'b0;
            div_fin   <= 1'b0;
            cnt       <= '0;
            clr_q     <= '0;
            grn_q     <= '0;
            grn_p     <= '0;
            filter    <= FLT_CLEAR;
            clear_cnt <= '0;
            green_pct <= '0;
            valid     <= 1'b0;
            color     <= 1'b0;
            div_err   <= 1'b0;
`ifdef COLOR_RATIO_RGB_EN
            red_q     <= '0;
            blu_q     <= '0;
            red_p     <= '0;
            blu_p     <= '0;
            red_pct   <= '0;
            blue_pct  <= '0;
`endif
        end else begin
            sync      <= {sync[1:0], freq_in};
            timer     <= (state_n != state) ? '0 : timer + 32'd1;
            valid     <= 1'b0;
            div_start <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (en) begin
                        filter <= FLT_CLEAR;
                        phase  <= 2'd0;
                    end
                end
                SETTLE: cnt <= '0;
                GATE: begin
                    cnt <= cnt_nxt;
                    if (gate_end) begin
                        if (phase == 2'd0) clr_q <= cnt_nxt;
                        else if (phase == 2'd1) grn_q <= cnt_nxt;
`ifdef COLOR_RATIO_RGB_EN
                        else if (phase == 2'd2) red_q <= cnt_nxt;
                        else blu_q <= cnt_nxt;
`endif
                        if (phase != LAST_PH) begin
                            phase  <= phase + 2'd1;
                            filter <= phase_flt(phase + 2'd1);
                        end else begin
                            // A zero clear count skips the divider entirely.
                            div_idx   <= 2'd0;
                            div_fin   <= (clr_q == '0);
                            div_start <= (clr_q != '0);
                            grn_p     <= '0;
`ifdef COLOR_RATIO_RGB_EN
                            red_p     <= '0;
                            blu_p     <= '0;
`endif
                        end
                    end
                end
                DIV: begin
                    if (dv_done) begin
                        if (div_idx == 2'd0) grn_p <= dv_pct;
`ifdef COLOR_RATIO_RGB_EN
                        else if (div_idx == 2'd1) red_p <= dv_pct;
                        else blu_p <= dv_pct;
`endif
                        if (div_idx == LAST_DIV) begin
                            div_fin <= 1'b1;
                        end else begin
                            div_idx   <= div_idx + 2'd1;
                            div_start <= 1'b1;
                        end
                    end
                    if (div_fin) begin
                        clear_cnt <= clr_q;
                        green_pct <= grn_p;
                        div_err   <= (clr_q == '0);
                        color     <= (32'(grn_p) >= LO_PCT) &&
                                     (32'(grn_p) <= HI_PCT);
                        valid     <= 1'b1;
`ifdef COLOR_RATIO_RGB_EN
                        red_pct   <= red_p;
                        blue_pct  <= blu_p;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    pct_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .start(div_start),
        .num  (dv_num),
        .den  (clr_q),
        .done (dv_done),
        .pct  (dv_pct)
    );

endmodule

// File: tb/tb_color_ratio_meter.sv
// Randomised self-checking bench for color_ratio_meter.
// Reference ratios come from plain integer arithmetic on edge counts.
module tb_color_ratio_meter;

    localparam int GATE   = 1000;
    localparam int SETTLE = 10;
    localparam int CW     = 8;
    localparam int SAT    = (1 << CW) - 1;

    typedef struct {
        int c;
        int g;
        int r;
        int b;
        bit keep;
    } meas_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          freq_in = 1'b0;
    logic [1:0]    filter;
    logic [CW-1:0] clear_cnt;
    logic [6:0]    green_pct;
    logic          valid, color, div_err, busy;
`ifdef COLOR_RATIO_RGB_EN
    logic [6:0]    red_pct, blue_pct;
`endif

    int npass = 0;
    int ntot  = 0;

    color_ratio_meter #(
        .GATE_CYCLES  (GATE),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW),
        .LO_PCT       (57),
        .HI_PCT       (80)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .freq_in  (freq_in),
        .filter   (filter),
        .clear_cnt(clear_cnt),
        .green_pct(green_pct),
`ifdef COLOR_RATIO_RGB_EN
        .red_pct  (red_pct),
        .blue_pct (blue_pct),
`endif
        .valid    (valid),
        .color    (color),
        .div_err  (div_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic int ref_pct(input int c, input int x);
        int q;
        if (sat(c) == 0) return 0;
        q = (sat(x) * 100) / sat(c);
        return (q > 100) ? 100 : q;
    endfunction

    // Settle-window noise, then n real pulses well inside the gate.
    task automatic drive(input int n);
        tick; freq_in = 1'b1;
        tick; tick; freq_in = 1'b0;
        tick; freq_in = 1'b1;
        tick; freq_in = 1'b0;
        repeat (10) tick;
        for (int i = 0; i < n; i++) begin
            freq_in = 1'b1;
            tick;
            freq_in = 1'b0;
            repeat ($urandom_range(1, 2)) tick;
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_filter"}, int'(filter), 2);
        chk({p, "_clear_cnt"}, int'(clear_cnt), 0);
        chk({p, "_green_pct"}, int'(green_pct), 0);
        chk({p, "_valid"}, int'(valid), 0);
        chk({p, "_color"}, int'(color), 0);
        chk({p, "_div_err"}, int'(div_err), 0);
        chk({p, "_busy"}, int'(busy), 0);
`ifdef COLOR_RATIO_RGB_EN
        chk({p, "_red_pct"}, int'(red_pct), 0);
        chk({p, "_blue_pct"}, int'(blue_pct), 0);
`endif
    endtask

    task automatic measure(input meas_t m);
        int cnts[4];
        int seq[4];
        int nph;
        int n;
        int gp;
        logic [1:0] prev;
        cnts = '{m.c, m.g, m.r, m.b};
        seq  = '{2, 3, 0, 1};
`ifdef COLOR_RATIO_RGB_EN
        nph = 4;
`else
        nph = 2;
`endif
        if (!busy) begin
            en = 1'b1;
            n = 0;
            while (!busy && n < 20) begin tick; n++; end
            chk("start_busy", int'(busy), 1);
        end else begin
            tick;
            chk("valid_one_cycle", int'(valid), 0);
        end
        en = m.keep;
        for (int p = 0; p < nph; p++) begin
            if (p > 0) begin
                n = 0;
                while (filter == prev && n < 1200) begin tick; n++; end
            end
            chk($sformatf("filter_ph%0d", p), int'(filter), seq[p]);
            prev = filter;
            drive(cnts[p]);
        end
        n = 0;
        while (!valid && n < 1500) begin tick; n++; end
        chk("valid_seen", int'(valid), 1);
        gp = ref_pct(m.c, m.g);
        chk($sformatf("clear_cnt c=%0d", m.c), int'(clear_cnt), sat(m.c));
        chk($sformatf("green_pct c=%0d g=%0d", m.c, m.g),
            int'(green_pct), gp);
        chk($sformatf("color pct=%0d", gp), int'(color),
            int'(gp >= 57 && gp <= 80));
        chk("div_err", int'(div_err), int'(sat(m.c) == 0));
`ifdef COLOR_RATIO_RGB_EN
        chk($sformatf("red_pct c=%0d r=%0d", m.c, m.r),
            int'(red_pct), ref_pct(m.c, m.r));
        chk($sformatf("blue_pct c=%0d b=%0d", m.c, m.b),
            int'(blue_pct), ref_pct(m.c, m.b));
`endif
    endtask

    task automatic finish_idle;
        tick;
        chk("valid_one_cycle", int'(valid), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        meas_t tbl[$];
        meas_t m;
        int n;
        bit seen;

        tbl.push_back('{200, 130, 60, 40, 1'b0});
        tbl.push_back('{200, 100, 10, 0, 1'b1});
        tbl.push_back('{200, 114, 250, 90, 1'b0});
        tbl.push_back('{0, 50, 30, 20, 1'b0});
        tbl.push_back('{200, 250, 150, 199, 1'b0});
        tbl.push_back('{300, 100, 255, 7, 1'b0});
        tbl.push_back('{250, 300, 260, 125, 1'b0});
        tbl.push_back('{200, 160, 1, 201, 1'b1});
        tbl.push_back('{200, 162, 45, 88, 1'b0});
        for (int i = 0; i < 4; i++) begin
            m.c = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 280);
            m.g = $urandom_range(0, 300);
            m.r = $urandom_range(0, 300);
            m.b = $urandom_range(0, 300);
            m.keep = 1'b0;
            tbl.push_back(m);
        end

        repeat (3) tick;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick;

        foreach (tbl[i]) begin
            measure(tbl[i]);
            if (!tbl[i].keep) finish_idle;
        end

        // Abort mid-gate: outputs drop to reset values, no late valid.
        en = 1'b1;
        tick;
        en = 1'b0;
        repeat (500) begin
            freq_in = ~freq_in;
            tick;
        end
        freq_in = 1'b0;
        rst_n = 1'b0;
        tick;
        chk_reset_vals("abort");
        rst_n = 1'b1;
        seen = 1'b0;
        n = 0;
        while (n < 3000) begin
            tick;
            if (valid || busy) seen = 1'b1;
            n++;
        end
        chk("abort_no_valid", int'(seen), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
